// File: rtl/uart_msg_tx.sv
// 8N1 UART serialiser for an NCHAR-byte ASCII message, most-significant byte first.
// Starts on an explicit send, or automatically when the message differs from the last one sent.
module uart_msg_tx #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned NCHAR     = 6,
  parameter bit          AUTO_SEND = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCHAR*8-1:0] message,
  input  logic               send,
  output logic               busy,
  output logic               done,
  output logic               txd
);

  localparam int unsigned MSG_W        = NCHAR * 8;
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned CHAR_W       = (NCHAR > 1) ? $clog2(NCHAR) : 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NCHAR - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,  state_d;
  logic [CNT_W-1:0]  baud_q,   baud_d;
  logic [2:0]        bit_q,    bit_d;
  logic [CHAR_W-1:0] char_q,   char_d;
  logic [MSG_W-1:0]  shadow_q, shadow_d;
  logic [MSG_W-1:0]  last_q,   last_d;
  logic              txd_q,    txd_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic       req;
  logic       bit_end;
  logic [2:0] bit_nxt;
  logic [7:0] cur_byte;

  // The shadow register shifts left after each character, so the byte on air is always its top byte.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    char_d   = char_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    req      = send | (AUTO_SEND & (message != last_q));
    bit_end  = (baud_q == BAUD_LAST);
    bit_nxt  = bit_q + 3'd1;
    cur_byte = shadow_q[MSG_W-1 -: 8];

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_START;
          shadow_d = message;
          last_d   = message;
          baud_d   = '0;
          bit_d    = '0;
          char_d   = '0;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = cur_byte[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nxt;
            txd_d = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (char_q == CHAR_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            char_d   = char_q + CHAR_W'(1);
            shadow_d = shadow_q << 8;
            state_d  = S_START;
            txd_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      // One not-busy cycle, so a held send always leaves idle-high time on the line.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      char_q   <= '0;
      shadow_q <= '0;
      last_q   <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx at 10 clocks per bit: one explicit-send instance, one auto-send instance.
module tb_uart_msg_tx;

  localparam logic [47:0] M0125 = 48'h3031_3235_0D0A;
  localparam logic [47:0] MPAID = 48'h5041_4944_0D0A;
  localparam logic [47:0] M0030 = 48'h3030_3330_0D0A;
  localparam logic [47:0] M0050 = 48'h3030_3530_0D0A;

  logic        clk;
  logic        reset;
  logic [47:0] message;
  logic        send;
  logic        busy, done, txd;
  logic [47:0] msg_a;
  logic        send_a;
  logic        busy_a, done_a, txd_a;

  int checks = 0;
  int errors = 0;

  logic s_txd  [0:2100];
  logic s_busy [0:2100];
  logic s_done [0:2100];

  uart_msg_tx #(.CLK_HZ(1000), .BAUD(100), .NCHAR(6), .AUTO_SEND(1'b0)) u_dut (
    .clk(clk), .reset(reset), .message(message), .send(send),
    .busy(busy), .done(done), .txd(txd)
  );

  uart_msg_tx #(.CLK_HZ(1000), .BAUD(100), .NCHAR(6), .AUTO_SEND(1'b1)) u_auto (
    .clk(clk), .reset(reset), .message(msg_a), .send(send_a),
    .busy(busy_a), .done(done_a), .txd(txd_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample one instance on n falling edges; k=1 is the cycle after the accepting edge.
  task automatic record(input int n, input bit use_auto, input bit pulse, input int flip_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_txd[k]  = use_auto ? txd_a  : txd;
      s_busy[k] = use_auto ? busy_a : busy;
      s_done[k] = use_auto ? done_a : done;
      if (pulse && k == 1) send = 1'b0;
      if (k == flip_at) message = '0;
    end
  endtask

  // A frame occupying samples base+1..base+600, decoded at mid-bit, then DONE at base+601.
  task automatic check_frame(input int base, input logic [47:0] msg, input string tag);
    int nb;
    int nd;
    logic [7:0] b;
    logic [7:0] exp;
    nb = 0;
    nd = 0;
    for (int k = base + 1; k <= base + 600; k++) begin
      nb += int'(s_busy[k]);
      nd += int'(s_done[k]);
    end
    check($sformatf("%s busy_len", tag), nb, 600);
    check($sformatf("%s done_early", tag), nd, 0);
    check($sformatf("%s done_601", tag), int'(s_done[base+601]), 1);
    check($sformatf("%s busy_601", tag), int'(s_busy[base+601]), 0);
    check($sformatf("%s txd_601", tag), int'(s_txd[base+601]), 1);
    for (int c = 0; c < 6; c++) begin
      exp = 8'(msg >> (8 * (5 - c)));
      for (int bi = 0; bi < 8; bi++) b[bi] = s_txd[base + c*100 + 10*(bi+1) + 5];
      check($sformatf("%s ch%0d start", tag, c), int'(s_txd[base + c*100 + 5]), 0);
      check($sformatf("%s ch%0d byte", tag, c), int'(b), int'(exp));
      check($sformatf("%s ch%0d stop", tag, c), int'(s_txd[base + c*100 + 95]), 1);
    end
  endtask

  initial begin
    int gap;
    int ngaps;
    int nd;
    int nb;

    reset   = 1'b1;
    send    = 1'b0;
    message = '0;
    send_a  = 1'b0;
    msg_a   = '0;

    // Reset held 3 cycles, then a quiet idle line.
    repeat (3) @(negedge clk);
    check("reset_state", int'({txd, busy, done}), 4);
    check("reset_state_auto", int'({txd_a, busy_a, done_a}), 4);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_50", int'({txd, busy, done}), 4);
    end

    // Single send pulse.
    message = M0125;
    send    = 1'b1;
    record(610, 1'b0, 1'b1, 0);
    check_frame(0, M0125, "msg0125");

    // Message cleared mid-frame must not disturb the frame.
    message = MPAID;
    send    = 1'b1;
    record(610, 1'b0, 1'b1, 100);
    check_frame(0, MPAID, "paid");

    // send held: back-to-back messages with a 2-cycle idle-high gap.
    message = M0125;
    send    = 1'b1;
    record(2000, 1'b0, 1'b0, 0);
    send  = 1'b0;
    gap   = 0;
    ngaps = 0;
    nd    = 0;
    for (int k = 2; k <= 2000; k++) begin
      nd += int'(s_done[k]);
      if (!s_busy[k] && s_txd[k]) gap++;
      if (s_busy[k] && !s_busy[k-1]) begin
        check("hold_gap", gap, 2);
        ngaps++;
        gap = 0;
      end
    end
    check("hold_ngaps", ngaps, 3);
    check("hold_dones", nd, 3);
    check_frame(0, M0125, "hold0");
    check_frame(602, M0125, "hold1");
    check_frame(1204, M0125, "hold2");
    repeat (700) @(negedge clk);
    check("hold_drained", int'({txd, busy}), 2);

    // Reset mid-frame.
    message = M0125;
    send    = 1'b1;
    record(249, 1'b0, 1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset", int'({txd, busy, done}), 4);
    reset = 1'b0;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      nd += int'(done);
      nb += int'(busy);
    end
    check("midreset_no_done", nd, 0);
    check("midreset_no_busy", nb, 0);
    send = 1'b1;
    record(610, 1'b0, 1'b1, 0);
    check_frame(0, M0125, "after_reset");

    // Auto-send on message change, nothing further while the message is stable.
    msg_a = M0030;
    record(610, 1'b1, 1'b0, 0);
    check_frame(0, M0030, "auto0030");
    msg_a = M0050;
    record(610, 1'b1, 1'b0, 0);
    check_frame(0, M0050, "auto0050");
    nb = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      nb += int'(busy_a);
    end
    check("auto_stable", nb, 0);
    check("auto_idle_txd", int'(txd_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
